// File: rtl/dcache_wbuf_axi.sv
// Dirty-line write-back buffer for the data cache.
// Holds one victim line and drains it as a single AXI INCR burst: AW, then all W beats, then B.
module dcache_wbuf_axi #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      wbuf_we,
    input  logic                      wbuf_reset,
    input  logic [ADDR_WIDTH-1:0]     line_addr,
    input  logic [LINE_BYTES*8-1:0]   line_data,
    input  logic                      w_req,
    output logic                      w_rdy,
    output logic                      wrt_finish,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic                      wvalid,
    input  logic                      wready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wlast,
    input  logic                      bvalid,
    output logic                      bready,
    input  logic [1:0]                bresp
);

    localparam int OFS       = $clog2(LINE_BYTES);
    localparam int LINE_BITS = LINE_BYTES * 8;
    localparam int BEATS     = LINE_BITS / DATA_WIDTH;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int DW_LOG    = $clog2(DATA_WIDTH);
    localparam int LINE_LOG  = $clog2(LINE_BITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic [BEAT_W-1:0]         beat_r;
    logic [BEAT_W-1:0]         beat_s;
    logic                      loaded_r;
    logic                      loaded_s;
    logic                      finish_r;
    logic                      finish_s;
    logic                      awvalid_r;
    logic                      wvalid_r;
    logic                      bready_r;
    logic                      w_rdy_s;
    logic                      capture_s;
    logic                      last_beat_s;
    logic [LINE_LOG-1:0]       bit_ofs_s;
    logic [ADDR_WIDTH-OFS-1:0] addr_r;
    logic [LINE_BITS-1:0]      line_r;
    logic                      unused_s;

    assign capture_s   = (state_r == ST_IDLE) && wbuf_we;
    assign last_beat_s = (beat_r == BEAT_W'(BEATS - 1));
    assign bit_ofs_s   = {beat_r, {DW_LOG{1'b0}}};

    // Next-state, beat counter and buffer-status decisions
    always_comb begin
        state_s  = state_r;
        beat_s   = beat_r;
        loaded_s = loaded_r;
        finish_s = finish_r;
        w_rdy_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                beat_s = '0;
                if (w_req && loaded_r) begin
                    w_rdy_s = 1'b1;
                    state_s = ST_AW;
                end else begin
                    state_s = ST_IDLE;
                end
                // A capture beats a simultaneous wbuf_reset: the new line is loaded, finish clears
                if (wbuf_we) begin
                    loaded_s = 1'b1;
                    finish_s = 1'b0;
                end else if (wbuf_reset) begin
                    loaded_s = 1'b0;
                    finish_s = 1'b0;
                end else begin
                    loaded_s = loaded_r;
                    finish_s = finish_r;
                end
            end
            ST_AW: begin
                beat_s = '0;
                if (awready) begin
                    state_s = ST_W;
                end else begin
                    state_s = ST_AW;
                end
                if (wbuf_reset) begin
                    loaded_s = 1'b0;
                    finish_s = 1'b0;
                end else begin
                    loaded_s = loaded_r;
                    finish_s = finish_r;
                end
            end
            ST_W: begin
                if (wready && last_beat_s) begin
                    beat_s  = '0;
                    state_s = ST_B;
                end else if (wready) begin
                    beat_s  = beat_r + BEAT_W'(1);
                    state_s = ST_W;
                end else begin
                    beat_s  = beat_r;
                    state_s = ST_W;
                end
                if (wbuf_reset) begin
                    loaded_s = 1'b0;
                    finish_s = 1'b0;
                end else begin
                    loaded_s = loaded_r;
                    finish_s = finish_r;
                end
            end
            ST_B: begin
                beat_s = '0;
                // The B handshake outranks a same-cycle wbuf_reset
                if (bvalid) begin
                    state_s  = ST_IDLE;
                    finish_s = 1'b1;
                    loaded_s = 1'b0;
                end else if (wbuf_reset) begin
                    state_s  = ST_B;
                    finish_s = 1'b0;
                    loaded_s = 1'b0;
                end else begin
                    state_s  = ST_B;
                    finish_s = finish_r;
                    loaded_s = loaded_r;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                beat_s   = '0;
                loaded_s = 1'b0;
                finish_s = 1'b0;
            end
        endcase
    end

    // State, counter and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            beat_r    <= '0;
            loaded_r  <= 1'b0;
            finish_r  <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            beat_r    <= beat_s;
            loaded_r  <= loaded_s;
            finish_r  <= finish_s;
            awvalid_r <= (state_s == ST_AW);
            wvalid_r  <= (state_s == ST_W);
            bready_r  <= (state_s == ST_B);
        end
    end

    // Line buffer; keeps its contents through reset and is only written while idle
    always_ff @(posedge clk) begin
        if (rstn && capture_s) begin
            addr_r <= line_addr[ADDR_WIDTH-1:OFS];
            line_r <= line_data;
        end else begin
            addr_r <= addr_r;
            line_r <= line_r;
        end
    end

    assign w_rdy      = w_rdy_s & rstn;
    assign wrt_finish = finish_r;
    assign awvalid    = awvalid_r;
    assign awaddr     = {addr_r, {OFS{1'b0}}};
    assign awlen      = 8'(BEATS - 1);
    assign awsize     = 3'($clog2(STRB_W));
    assign awburst    = 2'b01;
    assign wvalid     = wvalid_r;
    assign wdata      = line_r[bit_ofs_s +: DATA_WIDTH];
    assign wstrb      = {STRB_W{1'b1}};
    assign wlast      = wvalid_r & last_beat_s;
    assign bready     = bready_r;

    // Response code and line offset bits carry no information for this buffer
    assign unused_s = ^{bresp, line_addr[OFS-1:0]};

endmodule

// File: tb/tb_dcache_wbuf_axi.sv
// Randomized bench for dcache_wbuf_axi: a transaction-level model of the buffer predicts
// every AXI field, beat order, w_rdy pulse and wrt_finish level cycle by cycle.
module tb_dcache_wbuf_axi;

    localparam int AW    = 32;
    localparam int LB    = 64;
    localparam int DW    = 32;
    localparam int BEATS = LB * 8 / DW;

    logic            clk = 1'b0;
    logic            rstn;
    logic            wbuf_we;
    logic            wbuf_reset;
    logic [AW-1:0]   line_addr;
    logic [LB*8-1:0] line_data;
    logic            w_req;
    logic            w_rdy;
    logic            wrt_finish;
    logic            awvalid;
    logic            awready;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            wvalid;
    logic            wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;

    dcache_wbuf_axi #(.ADDR_WIDTH(AW), .LINE_BYTES(LB), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rstn(rstn), .wbuf_we(wbuf_we), .wbuf_reset(wbuf_reset),
        .line_addr(line_addr), .line_data(line_data), .w_req(w_req), .w_rdy(w_rdy),
        .wrt_finish(wrt_finish), .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst), .wvalid(wvalid),
        .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .bvalid(bvalid),
        .bready(bready), .bresp(bresp)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the buffer as seen from outside
    logic            m_loaded;
    logic            m_finish;
    logic [LB*8-1:0] m_line;
    logic [AW-1:0]   m_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LB*8-1:0] rand_line();
        logic [LB*8-1:0] l;
        for (int i = 0; i < BEATS; i++) l[i*DW +: DW] = $urandom();
        return l;
    endfunction

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_awv"}, awvalid, 1'b0);
        chk({tag, "_wv"}, wvalid, 1'b0);
        chk({tag, "_br"}, bready, 1'b0);
        chk({tag, "_rdy"}, w_rdy, w_req && m_loaded);
        chk({tag, "_fin"}, wrt_finish, m_finish);
        @(posedge clk);
        #1;
    endtask

    // Capture one line, request it, then act as a stalling AXI slave until B or abort.
    task automatic burst(input logic [AW-1:0] addr, input logic [LB*8-1:0] line,
                         input int max_stall, input logic [1:0] resp, input bit mid_we,
                         input int rst_beat, output int cyc);
        int  phase;
        int  k;
        int  stall;
        bit  do_rst;
        line_addr  = addr;
        line_data  = line;
        wbuf_we    = 1'b1;
        wbuf_reset = 1'($urandom_range(0, 1));
        w_req      = 1'b0;
        @(negedge clk);
        chk("cap_rdy", w_rdy, 1'b0);
        chk("cap_fin", wrt_finish, m_finish);
        @(posedge clk);
        m_loaded = 1'b1;
        m_finish = 1'b0;
        m_line   = line;
        m_addr   = addr;
        #1;
        wbuf_we    = 1'b0;
        wbuf_reset = 1'b0;
        line_data  = rand_line();
        line_addr  = $urandom();
        w_req      = 1'b1;
        @(negedge clk);
        chk("w_rdy", w_rdy, 1'b1);
        chk("acc_awv", awvalid, 1'b0);
        @(posedge clk);
        #1;
        phase = 0;
        k     = 0;
        cyc   = 1;
        stall = $urandom_range(0, max_stall);
        bresp = resp;
        while (phase < 3 && cyc < 400) begin
            awready    = (phase == 0) && (stall == 0);
            wready     = (phase == 1) && (stall == 0);
            bvalid     = (phase == 2) && (stall == 0);
            wbuf_we    = mid_we && ($urandom_range(0, 3) == 0);
            line_data  = rand_line();
            wbuf_reset = ($urandom_range(0, 3) == 0);
            do_rst     = (phase == 1) && (k == rst_beat);
            rstn       = !do_rst;
            @(negedge clk);
            chk("awvalid", awvalid, phase == 0);
            chk("wvalid", wvalid, phase == 1);
            chk("bready", bready, phase == 2);
            chk("rdy_once", w_rdy, 1'b0);
            chk("fin_busy", wrt_finish, m_finish);
            if (phase == 0) begin
                chk("awaddr", awaddr, {m_addr[AW-1:6], 6'b0});
                chk("awlen", awlen, 8'(BEATS - 1));
                chk("awsize", awsize, 3'd2);
                chk("awburst", awburst, 2'b01);
            end
            if (phase == 1) begin
                chk("wdata", wdata, m_line[k*DW +: DW]);
                chk("wlast", wlast, k == BEATS - 1);
                chk("wstrb", wstrb, 4'hF);
            end
            @(posedge clk);
            cyc++;
            if (do_rst) begin
                phase    = 4;
                m_loaded = 1'b0;
                m_finish = 1'b0;
            end else if (stall == 0) begin
                case (phase)
                    0: phase = 1;
                    1: begin
                        k++;
                        if (k == BEATS) phase = 2;
                    end
                    2: begin
                        phase    = 3;
                        m_finish = 1'b1;
                        m_loaded = 1'b0;
                    end
                    default: phase = 3;
                endcase
                stall = $urandom_range(0, max_stall);
            end else begin
                stall--;
            end
            #1;
        end
        chk("budget", phase >= 3, 1'b1);
        rstn       = 1'b1;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        wbuf_we    = 1'b0;
        wbuf_reset = 1'b0;
        // w_req remains high: a finished or aborted burst must not restart
        idle_check("post");
        w_req = 1'b0;
    endtask

    int          cyc;
    logic [511:0] t1_line;

    initial begin
        rstn       = 1'b0;
        wbuf_we    = 1'b0;
        wbuf_reset = 1'b0;
        line_addr  = '0;
        line_data  = '0;
        w_req      = 1'b1;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        bresp      = 2'b00;
        m_loaded   = 1'b0;
        m_finish   = 1'b0;
        m_line     = '0;
        m_addr     = '0;
        repeat (2) @(posedge clk);
        #1;
        idle_check("rst");
        rstn = 1'b1;
        idle_check("noload");
        w_req = 1'b0;

        // T1: zero-wait burst with known data and exact latency
        for (int i = 0; i < BEATS; i++) t1_line[i*DW +: DW] = 32'hA0 + 32'(i);
        burst(32'h1234_5678, t1_line, 0, 2'b00, 1'b0, -1, cyc);
        chk("t1_latency", 64'(cyc), 64'(BEATS + 3));

        // T4: wbuf_reset clears finish; w_req alone does not start a burst
        wbuf_reset = 1'b1;
        @(negedge clk);
        chk("t4_fin_before", wrt_finish, 1'b1);
        @(posedge clk);
        m_finish = 1'b0;
        m_loaded = 1'b0;
        #1;
        wbuf_reset = 1'b0;
        w_req      = 1'b1;
        repeat (3) idle_check("t4");
        w_req = 1'b0;

        // T2: random stalls
        for (int n = 0; n < 4; n++) burst($urandom(), rand_line(), 5, 2'b00, 1'b0, -1, cyc);

        // T3: capture attempts during the burst are ignored
        for (int n = 0; n < 2; n++) burst($urandom(), rand_line(), 3, 2'b01, 1'b1, -1, cyc);

        // T6: SLVERR response still counts as finished
        burst($urandom(), rand_line(), 2, 2'b10, 1'b0, -1, cyc);

        // T5: global reset on beat 7
        burst($urandom(), rand_line(), 2, 2'b00, 1'b1, 7, cyc);

        // Recovery after the aborted burst
        burst($urandom(), rand_line(), 1, 2'b00, 1'b0, -1, cyc);
        idle_check("end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
